// File: rtl/booth_seq_mult.sv
// booth_seq_mult: radix-4 Booth sequential signed multiplier with valid/ready operand and result handshakes
module booth_seq_mult #(
  parameter int WORDLEN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDLEN-1:0]     a,
  input  logic [WORDLEN-1:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WORDLEN-1:0]   product,
  output logic                   busy
);
  localparam int N  = WORDLEN / 2;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WORDLEN-1:0] mcand;
  logic [2*WORDLEN:0] p;
  logic [CW-1:0] cnt;
  logic [2:0] s;
  logic [WORDLEN+1:0] a_ext, mag, pp, acc;
  assign s     = p[2:0];
  assign a_ext = {{2{mcand[WORDLEN-1]}}, mcand};
  assign mag   = (s == 3'b011 || s == 3'b100) ? a_ext << 1 : (s[1] ^ s[0]) ? a_ext : '0;
  assign pp    = (mag ^ {(WORDLEN+2){s[2]}}) + {{(WORDLEN+1){1'b0}}, s[2]};
  // the W+2-bit accumulator keeps -2^(W-1) * -2^(W-1) exact
  assign acc   = {{2{p[2*WORDLEN]}}, p[2*WORDLEN:WORDLEN+1]} + pp;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = in_valid ? RUN : IDLE;
      RUN:     state_next = (cnt == CW'(N - 1)) ? DONE : RUN;
      DONE:    state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      mcand <= '0;
      p     <= '0;
      cnt   <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand <= a;
      p     <= {{WORDLEN{1'b0}}, b, 1'b0};
      cnt   <= '0;
    end else if (state == RUN) begin
      p     <= {acc, p[WORDLEN:2]};
      cnt   <= cnt + 1'b1;
    end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == RUN || state == DONE;
  assign product   = p[2*WORDLEN:1];
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and randomized checks of booth_seq_mult at WORDLEN 8 and 16
module tb_booth_seq_mult;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n;
  logic iv8, ir8, ov8, or8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic iv16, ir16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  int total = 0, bad = 0;

  booth_seq_mult #(.WORDLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );
  booth_seq_mult #(.WORDLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string tag);
    int lat = 0;
    iv8 = 1; a8 = x; b8 = y; or8 = 1;
    tick();
    iv8 = 0;
    while (!ov8 && lat < 20) begin tick(); lat++; end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_prod"}, 64'(p8), 64'(exp));
    tick();
    chk({tag, "_ov_once"}, 64'(ov8), 64'd0);
    chk({tag, "_ir_back"}, 64'(ir8), 64'd1);
  endtask

  task automatic rand8(input int n);
    logic [15:0] q[$];
    logic [15:0] e, got;
    logic fi, fo;
    int acc = 0, done = 0, cyc = 0;
    while (done < n && cyc < 60000) begin
      iv8 = (acc < n) && ($urandom_range(3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      or8 = $urandom_range(3) != 0;
      fi = iv8 && ir8; fo = ov8 && or8; got = p8;
      e = $signed(a8) * $signed(b8);
      tick();
      cyc++;
      if (fi) begin q.push_back(e); acc++; end
      if (fo) begin
        done++;
        if (q.size() == 0) chk("rand8_extra", 64'(got), 64'hdead);
        else chk("rand8_prod", 64'(got), 64'(q.pop_front()));
      end
    end
    iv8 = 0;
    chk("rand8_count", 64'(done), 64'(n));
    chk("rand8_accepted", 64'(acc), 64'(n));
  endtask

  task automatic rand16(input int n);
    logic [31:0] q[$];
    logic [31:0] e, got;
    logic fi, fo;
    int acc = 0, done = 0, cyc = 0;
    while (done < n && cyc < 60000) begin
      iv16 = (acc < n) && ($urandom_range(3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom);
      or16 = $urandom_range(3) != 0;
      fi = iv16 && ir16; fo = ov16 && or16; got = p16;
      e = $signed(a16) * $signed(b16);
      tick();
      cyc++;
      if (fi) begin q.push_back(e); acc++; end
      if (fo) begin
        done++;
        if (q.size() == 0) chk("rand16_extra", 64'(got), 64'hdead);
        else chk("rand16_prod", 64'(got), 64'(q.pop_front()));
      end
    end
    iv16 = 0;
    chk("rand16_count", 64'(done), 64'(n));
    chk("rand16_accepted", 64'(acc), 64'(n));
  endtask

  initial begin
    int lat;
    rst_n = 0; iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0;
    tick(); tick();
    chk("rst_ir", 64'(ir8), 64'd1);
    chk("rst_ov", 64'(ov8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_prod", 64'(p8), 64'd0);
    chk("rst_prod16", 64'(p16), 64'd0);
    rst_n = 1;
    tick();
    run8(8'd7, 8'd3, 16'h0015, "basic");
    run8(8'h80, 8'h80, 16'h4000, "minmin");
    run8(8'h80, 8'h7f, 16'hC080, "minmax");
    run8(8'h7f, 8'hff, 16'hFF81, "max_m1");
    run8(8'h00, 8'hff, 16'h0000, "zero_ones");
    run8(8'd85, 8'h00, 16'h0000, "x_zero");
    // backpressure: hold the result for 6 cycles, with a stray operand pulse that must be ignored
    iv8 = 1; a8 = 8'd5; b8 = 8'hF9; or8 = 0;
    tick();
    iv8 = 0; lat = 0;
    while (!ov8 && lat < 20) begin tick(); lat++; end
    chk("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_prod", 64'(p8), 64'hFFDD);
      chk("bp_ir", 64'(ir8), 64'd0);
      chk("bp_ov", 64'(ov8), 64'd1);
      iv8 = (i == 1);
      a8 = 8'd9; b8 = 8'd9;
      tick();
    end
    iv8 = 0; or8 = 1;
    tick();
    chk("bp_rel_ir", 64'(ir8), 64'd1);
    chk("bp_rel_ov", 64'(ov8), 64'd0);
    tick();
    chk("bp_no_phantom", 64'(busy8), 64'd0);
    // reset sampled at the second RUN edge
    iv8 = 1; a8 = 8'd100; b8 = 8'd100;
    tick();
    iv8 = 0;
    tick();
    chk("mid_busy", 64'(busy8), 64'd1);
    rst_n = 0;
    tick();
    chk("mid_rst_ir", 64'(ir8), 64'd1);
    chk("mid_rst_ov", 64'(ov8), 64'd0);
    chk("mid_rst_prod", 64'(p8), 64'd0);
    chk("mid_rst_busy", 64'(busy8), 64'd0);
    rst_n = 1;
    run8(8'hFD, 8'd5, 16'hFFF1, "post_rst");
    fork
      rand8(2000);
      rand16(2000);
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
